// File: rtl/axi_slave_fifo_param_if.sv
// AXI3 bus bundle between the fabric master and axi_slave_fifo_param.
// The slave modport is what the FIFO front-end sees; master drives the fabric side.
interface axi_slave_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4
);
  localparam int STRB_W = DATA_W / 8;

  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID, AWREADY;

  logic [ID_W-1:0]   WID;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST, WVALID, WREADY;

  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID, BREADY;

  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID, ARREADY;

  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST, RVALID, RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_slave_fifo_param.sv
// AXI3 slave front-end: write bursts land in an RX FIFO (data+strobe), read bursts
// drain a TX FIFO filled by the local component. Read and write paths are independent.

module axi_slave_fifo_param_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] cnt_o
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [CW-1:0]           cnt_q;
  logic                    do_push, do_pop;

  // A push at full is only taken when a real pop frees the slot in the same cycle.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  assign dout_o = mem_q[rptr_q];
  assign cnt_o  = cnt_q;
endmodule

module axi_slave_fifo_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int ID_W     = 4,
  parameter int LEN_W    = 4,
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4,
  localparam int STRB_W  = DATA_W / 8,
  localparam int RX_CW   = $clog2(RX_DEPTH) + 1,
  localparam int TX_CW   = $clog2(TX_DEPTH) + 1
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  axi_slave_fifo_param_if.slave s_axi,
  output logic [ID_W-1:0]     SLAVE_AWID,
  output logic [ADDR_W-1:0]   SLAVE_WADDRREG,
  output logic [LEN_W-1:0]    SLAVE_AWLEN,
  output logic [2:0]          SLAVE_AWSIZE,
  output logic [1:0]          SLAVE_AWBURST,
  output logic                IssueWrite,
  input  logic                Got_IssueWrite,
  output logic [DATA_W-1:0]   SLAVE_WDATAREG,
  output logic [STRB_W-1:0]   SLAVE_WSTRB,
  output logic                SLAVE_WVALID,
  input  logic                S_INPUT_RE,
  output logic [ID_W-1:0]     SLAVE_ARID,
  output logic [ADDR_W-1:0]   SLAVE_RADDRREG,
  output logic [LEN_W-1:0]    SLAVE_ARLEN,
  output logic [2:0]          SLAVE_ARSIZE,
  output logic [1:0]          SLAVE_ARBURST,
  output logic                IssueRead,
  input  logic                Got_IssueRead,
  input  logic [DATA_W-1:0]   SLAVE_RDATAREG,
  input  logic                S_INPUT_WE,
  output logic                SLAVE_RFULL,
  input  logic                STOP_WREQ,
  output logic [RX_CW-1:0]    RX_COUNT,
  output logic [TX_CW-1:0]    TX_COUNT
);
  localparam int BW = LEN_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ctl_t;

  typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_DATA, W_RESP} wr_st_e;
  typedef enum logic       {R_IDLE, R_DATA}                  rd_st_e;

  // ---------------- write path ----------------
  wr_st_e            wr_st_q, wr_st_d;
  ctl_t              aw_q, aw_d;
  logic              awready_q, awready_d;
  logic              issuew_q, issuew_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              werr_q, werr_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;

  logic [RX_CW-1:0]         rx_cnt;
  logic [STRB_W+DATA_W-1:0] rx_head;
  logic                     wready, w_acc, rx_push, beat_err;
  logic [BW-1:0]            awlen_x;

  assign awlen_x = {1'b0, aw_q.len};
  assign wready  = (wr_st_q == W_DATA) && (rx_cnt != RX_CW'(RX_DEPTH));
  assign w_acc   = s_axi.WVALID && wready;
  // Overlong bursts are drained from the bus but never reach the component.
  assign rx_push = w_acc && (beat_q <= awlen_x);
  assign beat_err = (s_axi.WLAST && (beat_q != awlen_x)) ||
                    (!s_axi.WLAST && (beat_q == awlen_x));

  always_comb begin
    wr_st_d   = wr_st_q;
    aw_d      = aw_q;
    awready_d = 1'b0;
    issuew_d  = issuew_q;
    beat_d    = beat_q;
    werr_d    = werr_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    case (wr_st_q)
      W_IDLE: if (s_axi.AWVALID && !STOP_WREQ) begin
        aw_d      = '{id: s_axi.AWID, addr: s_axi.AWADDR, len: s_axi.AWLEN,
                      size: s_axi.AWSIZE, burst: s_axi.AWBURST};
        awready_d = 1'b1;
        issuew_d  = 1'b1;
        wr_st_d   = W_ISSUE;
      end
      W_ISSUE: if (Got_IssueWrite) begin
        issuew_d = 1'b0;
        beat_d   = '0;
        werr_d   = 1'b0;
        wr_st_d  = W_DATA;
      end
      W_DATA: if (w_acc) begin
        if (beat_q != '1) beat_d = beat_q + BW'(1);
        werr_d = werr_q | beat_err;
        if (s_axi.WLAST) begin
          bvalid_d = 1'b1;
          bid_d    = s_axi.WID;
          bresp_d  = (werr_q | beat_err) ? 2'b10 : 2'b00;
          wr_st_d  = W_RESP;
        end
      end
      W_RESP: if (s_axi.BREADY) begin
        bvalid_d = 1'b0;
        bresp_d  = 2'b00;
        wr_st_d  = W_IDLE;
      end
      default: wr_st_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_st_q   <= W_IDLE;
      aw_q      <= '0;
      awready_q <= 1'b0;
      issuew_q  <= 1'b0;
      beat_q    <= '0;
      werr_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      wr_st_q   <= wr_st_d;
      aw_q      <= aw_d;
      awready_q <= awready_d;
      issuew_q  <= issuew_d;
      beat_q    <= beat_d;
      werr_q    <= werr_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  axi_slave_fifo_param_fifo #(.W(STRB_W + DATA_W), .DEPTH(RX_DEPTH)) u_rx (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .push_i (rx_push),
    .pop_i  (S_INPUT_RE),
    .din_i  ({s_axi.WSTRB, s_axi.WDATA}),
    .dout_o (rx_head),
    .cnt_o  (rx_cnt)
  );

  // ---------------- read path ----------------
  rd_st_e            rd_st_q, rd_st_d;
  ctl_t              ar_q, ar_d;
  logic              arready_q, arready_d;
  logic              issuer_q, issuer_d;
  logic [BW-1:0]     rem_q, rem_d;

  logic [TX_CW-1:0]  tx_cnt;
  logic [DATA_W-1:0] tx_head;
  logic              rvalid, tx_pop;

  assign rvalid = (rd_st_q == R_DATA) && (tx_cnt != '0);
  assign tx_pop = rvalid && s_axi.RREADY;

  always_comb begin
    rd_st_d   = rd_st_q;
    ar_d      = ar_q;
    arready_d = 1'b0;
    issuer_d  = issuer_q;
    rem_d     = rem_q;
    if (Got_IssueRead) issuer_d = 1'b0;
    case (rd_st_q)
      R_IDLE: if (s_axi.ARVALID && !STOP_WREQ) begin
        ar_d      = '{id: s_axi.ARID, addr: s_axi.ARADDR, len: s_axi.ARLEN,
                      size: s_axi.ARSIZE, burst: s_axi.ARBURST};
        arready_d = 1'b1;
        issuer_d  = 1'b1;
        rem_d     = {1'b0, s_axi.ARLEN} + BW'(1);
        rd_st_d   = R_DATA;
      end
      R_DATA: if (tx_pop) begin
        rem_d = rem_q - BW'(1);
        if (rem_q == BW'(1)) rd_st_d = R_IDLE;
      end
      default: rd_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_st_q   <= R_IDLE;
      ar_q      <= '0;
      arready_q <= 1'b0;
      issuer_q  <= 1'b0;
      rem_q     <= '0;
    end else begin
      rd_st_q   <= rd_st_d;
      ar_q      <= ar_d;
      arready_q <= arready_d;
      issuer_q  <= issuer_d;
      rem_q     <= rem_d;
    end
  end

  axi_slave_fifo_param_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .push_i (S_INPUT_WE),
    .pop_i  (tx_pop),
    .din_i  (SLAVE_RDATAREG),
    .dout_o (tx_head),
    .cnt_o  (tx_cnt)
  );

  // ---------------- outputs ----------------
  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = wready;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BID     = bid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid;
  // FIFO storage is not reset, so heads are masked until an entry is valid.
  assign s_axi.RDATA   = rvalid ? tx_head : '0;
  assign s_axi.RID     = ar_q.id;
  assign s_axi.RRESP   = 2'b00;
  assign s_axi.RLAST   = (rd_st_q == R_DATA) && (rem_q == BW'(1));

  assign SLAVE_AWID     = aw_q.id;
  assign SLAVE_WADDRREG = aw_q.addr;
  assign SLAVE_AWLEN    = aw_q.len;
  assign SLAVE_AWSIZE   = aw_q.size;
  assign SLAVE_AWBURST  = aw_q.burst;
  assign IssueWrite     = issuew_q;
  assign SLAVE_WVALID   = (rx_cnt != '0);
  assign SLAVE_WDATAREG = SLAVE_WVALID ? rx_head[DATA_W-1:0] : '0;
  assign SLAVE_WSTRB    = SLAVE_WVALID ? rx_head[STRB_W+DATA_W-1:DATA_W] : '0;
  assign RX_COUNT       = rx_cnt;

  assign SLAVE_ARID     = ar_q.id;
  assign SLAVE_RADDRREG = ar_q.addr;
  assign SLAVE_ARLEN    = ar_q.len;
  assign SLAVE_ARSIZE   = ar_q.size;
  assign SLAVE_ARBURST  = ar_q.burst;
  assign IssueRead      = issuer_q;
  assign SLAVE_RFULL    = (tx_cnt == TX_CW'(TX_DEPTH));
  assign TX_COUNT       = tx_cnt;
endmodule

// File: tb/tb_axi_slave_fifo_param.sv
// Directed bench: table of write-burst cases plus hand sequences for
// backpressure, read bursts, STOP_WREQ and mid-burst reset.
module tb_axi_slave_fifo_param;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axi_slave_fifo_param_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .LEN_W(4)) ax ();

  logic [3:0]  SLAVE_AWID, SLAVE_ARID, SLAVE_AWLEN, SLAVE_ARLEN;
  logic [31:0] SLAVE_WADDRREG, SLAVE_RADDRREG, SLAVE_WDATAREG, SLAVE_RDATAREG;
  logic [2:0]  SLAVE_AWSIZE, SLAVE_ARSIZE, RX_COUNT, TX_COUNT;
  logic [1:0]  SLAVE_AWBURST, SLAVE_ARBURST;
  logic [3:0]  SLAVE_WSTRB;
  logic IssueWrite, IssueRead, SLAVE_WVALID, SLAVE_RFULL;
  logic Got_IssueWrite = 0, Got_IssueRead = 0, S_INPUT_RE = 0, S_INPUT_WE = 0, STOP_WREQ = 0;

  axi_slave_fifo_param #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .LEN_W(4),
                         .RX_DEPTH(4), .TX_DEPTH(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .s_axi(ax),
    .SLAVE_AWID(SLAVE_AWID), .SLAVE_WADDRREG(SLAVE_WADDRREG), .SLAVE_AWLEN(SLAVE_AWLEN),
    .SLAVE_AWSIZE(SLAVE_AWSIZE), .SLAVE_AWBURST(SLAVE_AWBURST),
    .IssueWrite(IssueWrite), .Got_IssueWrite(Got_IssueWrite),
    .SLAVE_WDATAREG(SLAVE_WDATAREG), .SLAVE_WSTRB(SLAVE_WSTRB), .SLAVE_WVALID(SLAVE_WVALID),
    .S_INPUT_RE(S_INPUT_RE),
    .SLAVE_ARID(SLAVE_ARID), .SLAVE_RADDRREG(SLAVE_RADDRREG), .SLAVE_ARLEN(SLAVE_ARLEN),
    .SLAVE_ARSIZE(SLAVE_ARSIZE), .SLAVE_ARBURST(SLAVE_ARBURST),
    .IssueRead(IssueRead), .Got_IssueRead(Got_IssueRead),
    .SLAVE_RDATAREG(SLAVE_RDATAREG), .S_INPUT_WE(S_INPUT_WE), .SLAVE_RFULL(SLAVE_RFULL),
    .STOP_WREQ(STOP_WREQ), .RX_COUNT(RX_COUNT), .TX_COUNT(TX_COUNT)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] awlen;
    int         nb;
    logic [3:0] wid;
    logic [3:0] strb;
    int         gwait;
    logic [1:0] bresp;
    int         enq;
  } wvec_t;

  wvec_t wv[5];

  task automatic aw_req(input logic [3:0] len, input logic [3:0] id);
    ax.AWVALID = 1; ax.AWLEN = len; ax.AWID = id; ax.AWADDR = 32'h4000_0000 | id;
    ax.AWSIZE = 3'd2; ax.AWBURST = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      if (ax.AWREADY) break;
    end
    ax.AWVALID = 0;
    check("awready", ax.AWREADY, 1);
    check("issuewrite_rise", IssueWrite, 1);
    check("awlen_latched", SLAVE_AWLEN, len);
    @(negedge ACLK);
    check("awready_pulse", ax.AWREADY, 0);
  endtask

  task automatic ar_req(input logic [3:0] len, input logic [3:0] id);
    ax.ARVALID = 1; ax.ARLEN = len; ax.ARID = id; ax.ARADDR = 32'h8000_0000;
    ax.ARSIZE = 3'd2; ax.ARBURST = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      if (ax.ARREADY) break;
    end
    ax.ARVALID = 0;
    check("arready", ax.ARREADY, 1);
    check("issueread_rise", IssueRead, 1);
    Got_IssueRead = 1;
    @(negedge ACLK);
    Got_IssueRead = 0;
    check("issueread_fall", IssueRead, 0);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic last,
                           input logic [3:0] id);
    for (int i = 0; i < 50 && !ax.WREADY; i++) @(negedge ACLK);
    if (!ax.WREADY) check("wready_timeout", ax.WREADY, 1);
    ax.WVALID = 1; ax.WDATA = d; ax.WSTRB = s; ax.WLAST = last; ax.WID = id;
    @(negedge ACLK);
    ax.WVALID = 0; ax.WLAST = 0;
  endtask

  task automatic run_wr(input wvec_t v, input logic [31:0] base);
    aw_req(v.awlen, v.wid);
    repeat (v.gwait) @(negedge ACLK);
    check("issuewrite_hold", IssueWrite, 1);
    Got_IssueWrite = 1;
    @(negedge ACLK);
    Got_IssueWrite = 0;
    check("issuewrite_fall", IssueWrite, 0);
    for (int b = 0; b < v.nb; b++) send_beat(base + b, v.strb, b == v.nb - 1, v.wid);
    check("bvalid", ax.BVALID, 1);
    check("bresp", ax.BRESP, v.bresp);
    check("bid", ax.BID, v.wid);
    ax.BREADY = 1;
    @(negedge ACLK);
    ax.BREADY = 0;
    check("bvalid_clear", ax.BVALID, 0);
    check("rx_count_enq", RX_COUNT, v.enq);
    for (int i = 0; i < v.enq; i++) begin
      check("rx_wvalid", SLAVE_WVALID, 1);
      check("rx_data", SLAVE_WDATAREG, base + i);
      check("rx_strb", SLAVE_WSTRB, v.strb);
      S_INPUT_RE = 1;
      @(negedge ACLK);
      S_INPUT_RE = 0;
    end
    check("rx_drained", {SLAVE_WVALID, RX_COUNT}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wv[0] = '{4'd3, 4, 4'd5, 4'hF, 2, 2'b00, 4};  // clean 4-beat burst
    wv[1] = '{4'd3, 2, 4'd6, 4'h3, 0, 2'b10, 2};  // early WLAST
    wv[2] = '{4'd1, 3, 4'd7, 4'hA, 1, 2'b10, 2};  // late WLAST, extra beat dropped
    wv[3] = '{4'd0, 1, 4'd1, 4'h1, 0, 2'b00, 1};  // single beat
    wv[4] = '{4'd2, 3, 4'd9, 4'hC, 1, 2'b00, 3};  // post-reset burst

    ax.AWVALID = 0; ax.AWID = 0; ax.AWADDR = 0; ax.AWLEN = 0; ax.AWSIZE = 0; ax.AWBURST = 0;
    ax.WID = 0; ax.WDATA = 0; ax.WSTRB = 0; ax.WLAST = 0; ax.WVALID = 0; ax.BREADY = 0;
    ax.ARVALID = 0; ax.ARID = 0; ax.ARADDR = 0; ax.ARLEN = 0; ax.ARSIZE = 0; ax.ARBURST = 0;
    ax.RREADY = 0; SLAVE_RDATAREG = 0;

    repeat (2) @(negedge ACLK);
    check("reset_outs", {ax.AWREADY, ax.WREADY, ax.BVALID, ax.ARREADY, ax.RVALID, ax.RLAST,
                         IssueWrite, IssueRead, SLAVE_WVALID, SLAVE_RFULL}, 0);
    check("reset_counts", {RX_COUNT, TX_COUNT}, 0);
    ARESETn = 1;

    for (int i = 0; i < 4; i++) run_wr(wv[i], 32'hC0DE_0000 + (i << 8));

    // RX backpressure: AWLEN=7 with the component not popping
    aw_req(4'd7, 4'd2);
    Got_IssueWrite = 1;
    @(negedge ACLK);
    Got_IssueWrite = 0;
    for (int b = 0; b < 4; b++) send_beat(32'hB000 + b, 4'hF, 0, 4'd2);
    check("bp_full_count", RX_COUNT, 4);
    check("bp_wready_low", ax.WREADY, 0);
    check("bp_head", SLAVE_WDATAREG, 32'hB000);
    ax.WVALID = 1; ax.WDATA = 32'hB004; ax.WSTRB = 4'hF; ax.WID = 4'd2;
    S_INPUT_RE = 1;
    @(negedge ACLK);
    S_INPUT_RE = 0;
    check("bp_after_pop", {ax.WREADY, RX_COUNT}, {1'b1, 3'd3});
    @(negedge ACLK);
    check("bp_one_more", {ax.WREADY, RX_COUNT}, {1'b0, 3'd4});
    @(negedge ACLK);
    check("bp_no_extra", RX_COUNT, 4);
    ax.WVALID = 0;
    S_INPUT_RE = 1;
    for (int b = 5; b < 8; b++) send_beat(32'hB000 + b, 4'hF, b == 7, 4'd2);
    check("bp_bresp", {ax.BVALID, ax.BRESP}, {1'b1, 2'b00});
    ax.BREADY = 1;
    for (int i = 0; i < 10 && RX_COUNT != 0; i++) @(negedge ACLK);
    S_INPUT_RE = 0; ax.BREADY = 0;
    check("bp_drained", RX_COUNT, 0);

    // Read burst ARLEN=2 with an overfilled TX FIFO and toggling RREADY
    ar_req(4'd2, 4'd9);
    for (int i = 0; i < 5; i++) begin
      S_INPUT_WE = 1; SLAVE_RDATAREG = 32'hA0 + i;
      @(negedge ACLK);
    end
    S_INPUT_WE = 0;
    check("tx_full", {SLAVE_RFULL, TX_COUNT}, {1'b1, 3'd4});
    begin
      int k;
      k = 0;
      for (int cyc = 0; cyc < 40 && k < 3; cyc++) begin
        ax.RREADY = (cyc % 3) != 1;
        if (ax.RVALID && ax.RREADY) begin
          check("rdata", ax.RDATA, 32'hA0 + k);
          check("rid", ax.RID, 9);
          check("rlast", ax.RLAST, k == 2);
          k++;
        end
        @(negedge ACLK);
      end
      ax.RREADY = 0;
      check("r_beats", k, 3);
    end
    check("r_surplus", {ax.RVALID, TX_COUNT}, {1'b0, 3'd1});
    ar_req(4'd0, 4'd3);
    check("r2_beat", {ax.RVALID, ax.RLAST, ax.RID, ax.RDATA}, {1'b1, 1'b1, 4'd3, 32'hA3});
    ax.RREADY = 1;
    @(negedge ACLK);
    ax.RREADY = 0;
    check("r2_done", {ax.RVALID, TX_COUNT}, 0);

    // STOP_WREQ gates both request channels
    STOP_WREQ = 1;
    ax.AWVALID = 1; ax.AWLEN = 4'd3; ax.AWID = 4'd4;
    ax.ARVALID = 1; ax.ARLEN = 4'd1; ax.ARID = 4'd6;
    repeat (3) begin
      @(negedge ACLK);
      check("stop_blocks", {ax.AWREADY, ax.ARREADY, IssueWrite, IssueRead}, 0);
    end
    STOP_WREQ = 0;
    @(negedge ACLK);
    check("stop_release", {ax.AWREADY, ax.ARREADY}, 2'b11);
    ax.AWVALID = 0; ax.ARVALID = 0;

    // Reset in the middle of both bursts
    Got_IssueWrite = 1; Got_IssueRead = 1;
    @(negedge ACLK);
    Got_IssueWrite = 0; Got_IssueRead = 0;
    send_beat(32'hD0, 4'hF, 0, 4'd4);
    send_beat(32'hD1, 4'hF, 0, 4'd4);
    S_INPUT_WE = 1; SLAVE_RDATAREG = 32'hE0;
    @(negedge ACLK);
    SLAVE_RDATAREG = 32'hE1;
    @(negedge ACLK);
    S_INPUT_WE = 0;
    check("pre_reset", {RX_COUNT, TX_COUNT, ax.RVALID}, {3'd2, 3'd2, 1'b1});
    #2 ARESETn = 0;
    #1;
    check("midreset_outs", {ax.AWREADY, ax.WREADY, ax.BVALID, ax.ARREADY, ax.RVALID, ax.RLAST,
                            IssueWrite, IssueRead, SLAVE_WVALID, SLAVE_RFULL}, 0);
    check("midreset_counts", {RX_COUNT, TX_COUNT}, 0);
    check("midreset_data", {ax.RDATA, SLAVE_WDATAREG, SLAVE_AWLEN, ax.RID}, 0);
    @(negedge ACLK);
    ARESETn = 1;
    run_wr(wv[4], 32'h5A5A_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
